// File: rtl/bram_table_sequencer_pkg.sv
// Shared types for the table sequencer: controller states and table depth helper.
// Combinational definitions only; no latency or backpressure of their own.
package bram_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    function automatic int unsigned table_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/bram_table_sequencer_arb.sv
// Two-way round-robin arbiter for the shared read port; grants are combinational from req.
// Zero latency; a losing requester stays pending until it wins, which is at most one cycle later.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Requester that wins when both ask; always the one not served most recently.
    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt[prio] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (|gnt) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/bram_table_sequencer.sv
// Loads a BRAM table from a valid/ready stream, then arbitrates its read port A between two requesters.
// Load: one word/cycle, s_ready low outside LOAD. Read: rd_valid one cycle after rd_gnt; requesters hold req until granted.
module bram_table_sequencer
    import bram_seq_pkg::*;
#(
    parameter int C_DATA_WIDTH    = 8,
    parameter int C_ADDRESS_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [C_DATA_WIDTH-1:0]    s_data,
    input  logic                       s_last,
    output logic                       loaded,
    output logic [C_ADDRESS_WIDTH:0]   words_loaded,
    output logic                       ram_wr_resetn,
    output logic                       ram_wr_en,
    output logic [C_DATA_WIDTH-1:0]    ram_wr_data,
    output logic [C_ADDRESS_WIDTH-1:0] ram_addrA,
    input  logic [C_DATA_WIDTH-1:0]    ram_qA,
    input  logic [1:0]                 rd_req,
    input  logic [C_ADDRESS_WIDTH-1:0] rd_addr0,
    input  logic [C_ADDRESS_WIDTH-1:0] rd_addr1,
    output logic [1:0]                 rd_gnt,
    output logic [1:0]                 rd_valid,
    output logic [C_DATA_WIDTH-1:0]    rd_data
);

    localparam logic [C_ADDRESS_WIDTH:0] DEPTH =
        (C_ADDRESS_WIDTH + 1)'(table_depth(C_ADDRESS_WIDTH));

    state_t state, state_nxt;
    logic   beat;
    logic   arb_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        s_ready       = 1'b0;
        beat          = 1'b0;
        ram_wr_resetn = 1'b0;
        loaded        = 1'b0;
        arb_en        = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ram_wr_resetn = 1'b1;
                s_ready       = (words_loaded < DEPTH);
                beat          = s_valid & s_ready;
                // Either an explicit last beat or a full table ends the load.
                if (beat && (s_last || words_loaded == DEPTH - 1'b1)) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                loaded = 1'b1;
                arb_en = 1'b1;
                if (load_start) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_loaded <= '0;
        end else if (state != LOAD && state_nxt == LOAD) begin
            words_loaded <= '0;
        end else if (beat) begin
            words_loaded <= words_loaded + (C_ADDRESS_WIDTH + 1)'(1);
        end
    end

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    // The container registers addrA, so data lines up with a one-cycle-delayed grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 2'b00;
        end else begin
            rd_valid <= rd_gnt;
        end
    end

    assign ram_wr_en   = beat;
    assign ram_wr_data = s_data;
    assign ram_addrA   = rd_gnt[1] ? rd_addr1 : rd_addr0;
    assign rd_data     = ram_qA;

endmodule

// File: tb/tb_bram_table_sequencer.sv
// Bench for bram_table_sequencer with a behavioural write-fill/read container model.
// Read results are checked through a scoreboard filled at grant time and drained on rd_valid.
module tb_bram_table_sequencer;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          loaded;
    logic [AW:0]   words_loaded;
    logic          ram_wr_resetn;
    logic          ram_wr_en;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_addrA;
    logic [DW-1:0] ram_qA;
    logic [1:0]    rd_req;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [1:0]    rd_gnt;
    logic [1:0]    rd_valid;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    bram_table_sequencer #(.C_DATA_WIDTH(DW), .C_ADDRESS_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .loaded        (loaded),
        .words_loaded  (words_loaded),
        .ram_wr_resetn (ram_wr_resetn),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_data   (ram_wr_data),
        .ram_addrA     (ram_addrA),
        .ram_qA        (ram_qA),
        .rd_req        (rd_req),
        .rd_addr0      (rd_addr0),
        .rd_addr1      (rd_addr1),
        .rd_gnt        (rd_gnt),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data)
    );

    // Container: write pointer held at 0 while wr_resetn is low, registered read on port A.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    always @(posedge clk) begin
        if (!ram_wr_resetn) begin
            wptr <= '0;
        end else if (ram_wr_en) begin
            mem[wptr] <= ram_wr_data;
            wptr      <= wptr + 1'b1;
        end
        ram_qA <= mem[ram_addrA];
    end

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_tbl [DEPTH];
    int            checks   = 0;
    int            failures = 0;
    int            last_gnt = 1;

    always @(negedge clk) begin : rd_monitor
        exp_t e;
        if (rd_valid != 2'b00) begin
            checks++;
            if (sb.size() == 0 || rd_valid == 2'b11) begin
                failures++;
                $display("FAIL rd_valid_unexpected got rd_valid=%b pending=%0d", rd_valid, sb.size());
            end else begin
                e = sb.pop_front();
                if (rd_valid !== (e.idx != 0 ? 2'b10 : 2'b01) || rd_data !== e.data) begin
                    failures++;
                    $display("FAIL rd_data req%0d got rd_valid=%b rd_data=%h expected data=%h",
                             e.idx, rd_valid, rd_data, e.data);
                end
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        rd_req = 2'b00; rd_addr0 = 8'd5; rd_addr1 = 8'd6;
        repeat (3) @(negedge clk);
        rd_req = 2'b11;
        #1;
        checks++;
        if ({s_ready, loaded, ram_wr_resetn, ram_wr_en} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got rdy/ld/wrn/wen=%b expected 0000",
                     {s_ready, loaded, ram_wr_resetn, ram_wr_en});
        end
        checks++;
        if (words_loaded !== 9'd0 || rd_gnt !== 2'b00 || rd_valid !== 2'b00) begin
            failures++;
            $display("FAIL reset_cnt got words=%0d gnt=%b vld=%b expected 0/00/00",
                     words_loaded, rd_gnt, rd_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (rd_gnt !== 2'b00 || ram_addrA !== 8'd5) begin
            failures++;
            $display("FAIL idle_no_grant got gnt=%b addrA=%0d expected 00/5", rd_gnt, ram_addrA);
        end
        rd_req = 2'b00;
    endtask

    task automatic test_full_load(input bit last_on_final);
        int            n    = 0;
        bit            done = 1'b0;
        int            cyc;
        logic [DW-1:0] d;
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        for (cyc = 0; cyc < DEPTH + 8; cyc++) begin
            d       = DW'($urandom);
            s_valid = 1'b1;
            s_data  = d;
            s_last  = last_on_final && (n == DEPTH - 1);
            #1;
            if (cyc == 0) begin
                checks++;
                if (words_loaded !== 9'd0 || loaded !== 1'b0 || ram_wr_resetn !== 1'b1 || s_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL load_entry got words=%0d loaded=%b wrn=%b rdy=%b expected 0/0/1/1",
                             words_loaded, loaded, ram_wr_resetn, s_ready);
                end
            end
            if (!ram_wr_en) begin
                done = 1'b1;
                break;
            end
            checks++;
            if (ram_wr_data !== d) begin
                failures++;
                $display("FAIL wr_data beat%0d got %h expected %h", n, ram_wr_data, d);
            end
            ref_tbl[n] = d;
            n++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (!done || n != DEPTH || cyc != DEPTH) begin
            failures++;
            $display("FAIL full_load_count got writes=%0d cycles=%0d expected %0d/%0d", n, cyc, DEPTH, DEPTH);
        end
        checks++;
        if (words_loaded !== 9'd256 || loaded !== 1'b1 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_load_state got words=%0d loaded=%b rdy=%b expected 256/1/0",
                     words_loaded, loaded, s_ready);
        end
    endtask

    task automatic test_short_load;
        int            n    = 0;
        bit            done = 1'b0;
        logic [DW-1:0] d;
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            d          = DW'($urandom);
            s_valid    = (cyc % 2 == 0);
            s_data     = d;
            s_last     = s_valid && (n == 4);
            load_start = (cyc == 3);
            #1;
            if (loaded) begin
                done = 1'b1;
                break;
            end
            checks++;
            if (ram_wr_en !== s_valid) begin
                failures++;
                $display("FAIL short_wr_en cyc%0d got %b expected %b", cyc, ram_wr_en, s_valid);
            end
            if (ram_wr_en) begin
                ref_tbl[n] = d;
                n++;
            end
            @(negedge clk);
        end
        load_start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        checks++;
        if (!done || n != 5 || words_loaded !== 9'd5 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL short_load got done=%b writes=%0d words=%0d rdy=%b expected 1/5/5/0",
                     done, n, words_loaded, s_ready);
        end
    endtask

    task automatic test_single_read;
        @(negedge clk);
        rd_req = 2'b01; rd_addr0 = 8'd3; rd_addr1 = 8'd77;
        #1;
        checks++;
        if (rd_gnt !== 2'b01 || ram_addrA !== 8'd3) begin
            failures++;
            $display("FAIL single_req0 got gnt=%b addrA=%0d expected 01/3", rd_gnt, ram_addrA);
        end
        sb.push_back('{0, ref_tbl[3]});
        last_gnt = 0;
        @(negedge clk);
        rd_req = 2'b10; rd_addr1 = 8'd200;
        #1;
        checks++;
        if (rd_gnt !== 2'b10 || ram_addrA !== 8'd200) begin
            failures++;
            $display("FAIL single_req1 got gnt=%b addrA=%0d expected 10/200", rd_gnt, ram_addrA);
        end
        sb.push_back('{1, ref_tbl[200]});
        last_gnt = 1;
        @(negedge clk);
        rd_req = 2'b00;
        #1;
        checks++;
        if (rd_gnt !== 2'b00) begin
            failures++;
            $display("FAIL idle_req got gnt=%b expected 00", rd_gnt);
        end
    endtask

    task automatic test_back_to_back;
        int            w;
        logic [AW-1:0] a;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_req   = 2'b11;
            rd_addr0 = AW'(10 + i);
            rd_addr1 = AW'(20 + i);
            #1;
            w = (last_gnt == 0) ? 1 : 0;
            a = (w != 0) ? rd_addr1 : rd_addr0;
            checks++;
            if (rd_gnt !== (w != 0 ? 2'b10 : 2'b01) || ram_addrA !== a) begin
                failures++;
                $display("FAIL b2b_grant%0d got gnt=%b addrA=%0d expected req%0d addrA=%0d",
                         i, rd_gnt, ram_addrA, w, a);
            end
            sb.push_back('{w, ref_tbl[a]});
            last_gnt = w;
        end
        @(negedge clk);
        rd_req = 2'b00;
    endtask

    task automatic test_reset_mid_load;
        logic [DW-1:0] d;
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d       = DW'($urandom);
            s_valid = 1'b1;
            s_data  = d;
            #1;
            if (ram_wr_en) ref_tbl[i] = d;
            @(negedge clk);
        end
        checks++;
        if (words_loaded !== 9'd10) begin
            failures++;
            $display("FAIL mid_load_count got %0d expected 10", words_loaded);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({loaded, ram_wr_resetn, s_ready, ram_wr_en} !== 4'b0000 || words_loaded !== 9'd0) begin
            failures++;
            $display("FAIL async_reset got ld/wrn/rdy/wen=%b words=%0d expected 0000/0",
                     {loaded, ram_wr_resetn, s_ready, ram_wr_en}, words_loaded);
        end
        @(negedge clk);
        reset    = 1'b0;
        s_valid  = 1'b0;
        last_gnt = 1;
    endtask

    task automatic test_load_during_read;
        logic [DW-1:0] d;
        @(negedge clk);
        rd_req = 2'b10; rd_addr1 = 8'd9; load_start = 1'b1;
        #1;
        checks++;
        if (rd_gnt !== 2'b10) begin
            failures++;
            $display("FAIL gnt_with_load got %b expected 10", rd_gnt);
        end
        sb.push_back('{1, ref_tbl[9]});
        last_gnt = 1;
        @(negedge clk);
        load_start = 1'b0; rd_req = 2'b11;
        #1;
        checks++;
        if (rd_gnt !== 2'b00 || words_loaded !== 9'd0 || loaded !== 1'b0 || ram_wr_resetn !== 1'b1) begin
            failures++;
            $display("FAIL reload_entry got gnt=%b words=%0d loaded=%b wrn=%b expected 00/0/0/1",
                     rd_gnt, words_loaded, loaded, ram_wr_resetn);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d = DW'($urandom);
            s_valid = 1'b1; s_data = d; s_last = (i == 2);
            #1;
            checks++;
            if (rd_gnt !== 2'b00) begin
                failures++;
                $display("FAIL load_no_grant beat%0d got %b expected 00", i, rd_gnt);
            end
            if (ram_wr_en) ref_tbl[i] = d;
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        #1;
        checks++;
        if (rd_gnt !== 2'b01 || words_loaded !== 9'd3) begin
            failures++;
            $display("FAIL reload_done got gnt=%b words=%0d expected 01/3", rd_gnt, words_loaded);
        end
        sb.push_back('{0, ref_tbl[rd_addr0]});
        last_gnt = 0;
        @(negedge clk);
        rd_req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_full_load(1'b0);
        test_single_read();
        test_back_to_back();
        test_full_load(1'b1);
        test_short_load();
        test_single_read();
        test_reset_mid_load();
        test_short_load();
        test_load_during_read();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d reads outstanding expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_table_sequencer.md
# bram_table_sequencer

Controller for the write-fill / dual-read block RAM container in the fscpu datapath. It sequences a table load from a valid/ready stream into the container's write port, then shares the container's read port A between two read requesters with round-robin arbitration and returns data with a valid strobe. The block lives between the stream source (DMA/register path) and the table consumers.

## Interface
- C_DATA_WIDTH, 8, table word width
- C_ADDRESS_WIDTH, 8, table address width; DEPTH = 2**C_ADDRESS_WIDTH
- clk  in  1  sole clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- load_start  in  1  pulse: begin (re)load of table
- s_valid  in  1  load stream beat valid
- s_ready  out  1  load stream ready
- s_data  in  C_DATA_WIDTH  load stream data
- s_last  in  1  final beat of table
- loaded  out  1  table valid, reads permitted
- words_loaded  out  C_ADDRESS_WIDTH+1  beats written in last/current load
- ram_wr_resetn  out  1  to container wr_resetn (high = write mode)
- ram_wr_en  out  1  to container wr_en
- ram_wr_data  out  C_DATA_WIDTH  to container wr_data
- ram_addrA  out  C_ADDRESS_WIDTH  to container addrA
- ram_qA  in  C_DATA_WIDTH  from container qA
- rd_req[0:1]  in  1 each  read request, held until granted
- rd_addr0, rd_addr1  in  C_ADDRESS_WIDTH  read addresses
- rd_gnt[0:1]  out  1 each  grant, combinational, same cycle as accepted request
- rd_valid[0:1]  out  1 each  read data valid
- rd_data  out  C_DATA_WIDTH  shared read data (= ram_qA)

## Operation
- States: IDLE, LOAD, READY. Reset -> IDLE.
- IDLE: ram_wr_resetn=0, s_ready=0, loaded=0, no grants. load_start -> LOAD.
- LOAD: ram_wr_resetn=1, s_ready=1 while words_loaded<DEPTH. ram_wr_en = s_valid & s_ready; ram_wr_data = s_data; words_loaded increments per accepted beat. Accepted beat with s_last, or accepted beat making words_loaded==DEPTH -> READY. load_start ignored. No grants.
- READY: ram_wr_resetn=0, s_ready=0, loaded=1. load_start -> LOAD, clears words_loaded and loaded next cycle.
- words_loaded is C_ADDRESS_WIDTH+1 bits so DEPTH is representable; no wrap. Cleared on entry to LOAD, held in READY.
- Arbitration (READY only): one request -> grant it. Both -> grant the one not granted most recently; pointer updates only on grant. Pointer resets to favour requester 0.
- ram_addrA = granted requester's address; otherwise rd_addr0.
- Container port B is not driven by this block.

## Timing
- Reset values: state IDLE, s_ready 0, loaded 0, words_loaded 0, ram_wr_resetn 0, ram_wr_en 0, rd_gnt 0, rd_valid 0, rr pointer 0.
- Load throughput: one word per cycle when s_valid held.
- Read latency: rd_valid[i] asserted exactly 1 cycle after rd_gnt[i]; rd_data valid that cycle. One grant per cycle max; back-to-back grants allowed.
- load_start in same cycle as a grant: grant still issued, rd_valid fires next cycle (data from old table), then LOAD.
- s_valid with s_last on beat DEPTH: single transition, words_loaded=DEPTH.
- Reset asserted mid-LOAD: immediate return to IDLE, partial table discarded (loaded=0).
- Zero-length load impossible: LOAD exits only on an accepted beat.

## Structure
- Package bram_seq_pkg: state enum (IDLE, LOAD, READY), DEPTH constant derivation helper.
- Sub-module rr_arbiter2: 2-way round-robin with registered last-grant pointer, enable input (READY), grant outputs.

## Test plan
- Load 256 beats, AW=8, s_valid continuous, no s_last -> ram_wr_en 256 cycles, words_loaded=256, READY, loaded=1, s_ready=0.
- Load 5 beats with s_last on 5th, s_valid toggled 1/0 -> exactly 5 writes, words_loaded=5, READY.
- READY, rd_req0 only addr 3 -> rd_gnt0 same cycle, ram_addrA=3, rd_valid0 next cycle, rd_data = word 3.
- Both requesters held 4 cycles -> grants alternate 0,1,0,1; rd_valid follows each grant by 1 cycle.
- Reset asserted after 10 of 20 beats -> IDLE, loaded=0, words_loaded=0, ram_wr_resetn=0 asynchronously.
- load_start in READY coincident with rd_req1 -> rd_gnt1, rd_valid1 next cycle, then LOAD with words_loaded cleared, no grants during LOAD.
